// File: rtl/score_bcd_tracker.sv
// score_bcd_tracker
// Converts the live binary score to three packed BCD digits with an
// iterative shift-add-3 converter, and tracks the session high score
// captured on each rising edge of game_over.
//
// state | meaning
// IDLE  | converter inactive, watching for score / high-score requests
// CONV  | one shift/adjust iteration per cycle, SCORE_W cycles
// WRITE | commit the converted digits to bcd_score or bcd_high

module score_bcd_tracker #(
    parameter int SCORE_W = 9,
    parameter int DIGITS  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score,
    input  logic                  game_over,
    output logic [4*DIGITS-1:0]   bcd_score,
    output logic [4*DIGITS-1:0]   bcd_high,
    output logic                  busy,
    output logic                  new_high
);

    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(SCORE_W + 1);

    // Saturation ceiling; at widths below 10 bits the input can never exceed 999.
    localparam logic [SCORE_W-1:0] MAX_VAL = (SCORE_W >= 10) ? SCORE_W'(999) : '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic TAG_SCORE = 1'b0;
    localparam logic TAG_HIGH  = 1'b1;

    state_t              state_q, state_d;
    logic [SCORE_W-1:0]  bin_q, bin_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic                tag_q, tag_d;
    logic [SCORE_W-1:0]  last_score_q, last_score_d;
    logic [SCORE_W-1:0]  high_bin_q, high_bin_d;
    logic                high_req_q, high_req_d;
    logic                game_over_dly_q, game_over_dly_d;
    logic [BW-1:0]       bcd_score_q, bcd_score_d;
    logic [BW-1:0]       bcd_high_q, bcd_high_d;
    logic                busy_q, busy_d;
    logic                new_high_q, new_high_d;

    logic [BW-1:0]       bcd_adj;
    logic [SCORE_W-1:0]  score_clamped;
    logic                go_rise;

    assign score_clamped = (score > MAX_VAL) ? MAX_VAL : score;
    assign go_rise       = game_over & ~game_over_dly_q;

    // Add-3 correction on every digit that would overflow when doubled.
    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic: converter FSM plus high-score capture on game_over edges.
    always_comb begin
        state_d         = state_q;
        bin_d           = bin_q;
        bcd_d           = bcd_q;
        iter_d          = iter_q;
        tag_d           = tag_q;
        last_score_d    = last_score_q;
        high_bin_d      = high_bin_q;
        high_req_d      = high_req_q;
        game_over_dly_d = game_over;
        bcd_score_d     = bcd_score_q;
        bcd_high_d      = bcd_high_q;
        new_high_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (score != last_score_q) begin
                    bin_d        = score_clamped;
                    bcd_d        = '0;
                    iter_d       = '0;
                    last_score_d = score;
                    tag_d        = TAG_SCORE;
                    state_d      = ST_CONV;
                end else if (high_req_q) begin
                    bin_d      = high_bin_q;
                    bcd_d      = '0;
                    iter_d     = '0;
                    tag_d      = TAG_HIGH;
                    high_req_d = 1'b0;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d  = {bcd_adj[BW-2:0], bin_q[SCORE_W-1]};
                bin_d  = {bin_q[SCORE_W-2:0], 1'b0};
                iter_d = iter_q + 1'b1;
                if (iter_q == IW'(SCORE_W - 1)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (tag_q == TAG_HIGH) begin
                    bcd_high_d = bcd_q;
                    new_high_d = 1'b1;
                end else begin
                    bcd_score_d = bcd_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Evaluated after the FSM so an edge landing on the cycle the pending
        // request is consumed re-arms it rather than being lost.
        if (go_rise && (score > high_bin_q)) begin
            high_bin_d = (score > MAX_VAL) ? MAX_VAL : score;
            high_req_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            bin_q           <= '0;
            bcd_q           <= '0;
            iter_q          <= '0;
            tag_q           <= TAG_SCORE;
            last_score_q    <= '0;
            high_bin_q      <= '0;
            high_req_q      <= 1'b0;
            game_over_dly_q <= 1'b0;
            bcd_score_q     <= '0;
            bcd_high_q      <= '0;
            busy_q          <= 1'b0;
            new_high_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            bin_q           <= bin_d;
            bcd_q           <= bcd_d;
            iter_q          <= iter_d;
            tag_q           <= tag_d;
            last_score_q    <= last_score_d;
            high_bin_q      <= high_bin_d;
            high_req_q      <= high_req_d;
            game_over_dly_q <= game_over_dly_d;
            bcd_score_q     <= bcd_score_d;
            bcd_high_q      <= bcd_high_d;
            busy_q          <= busy_d;
            new_high_q      <= new_high_d;
        end
    end

    assign bcd_score = bcd_score_q;
    assign bcd_high  = bcd_high_q;
    assign busy      = busy_q;
    assign new_high  = new_high_q;

endmodule
